// File: rtl/mult12_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult12_seq_ctrl
//   Sequential 12x12 unsigned multiplier built around one shared 6x6
//   combinational array multiplier (unsigned_array_mult). An accepted operand
//   pair is split into 6-bit halves. Four partial products (lo*lo, hi*lo,
//   lo*hi, hi*hi) pass through the core on consecutive cycles and are
//   shift-accumulated into a 24-bit result.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous, active-high reset
//   in_valid   in   1   operand pair a/b valid
//   in_ready   out  1   operands accepted (high only in IDLE)
//   a, b       in   12  unsigned operands
//   out_valid  out  1   product valid, held until out_ready
//   out_ready  in   1   consumer accepts product
//   product    out  24  unsigned a*b
//   busy       out  1   operation in flight (MUL or DONE)
//
// Configuration
//   MULT12_ZERO_SKIP_EN : when defined, a pair with a zero operand runs no
//   passes and presents product=0 one clock after the accept edge.
//   When undefined, every pair takes all four passes.
// -----------------------------------------------------------------------------

// 6x6 unsigned array multiplier: one shifted AND-row per multiplier bit,
// summed row by row.
module unsigned_array_mult #(
    parameter int unsigned MW = 6
) (
    input  logic [MW-1:0]   x,
    input  logic [MW-1:0]   y,
    output logic [2*MW-1:0] p
);
    localparam int unsigned PW = 2 * MW;

    logic [PW-1:0] row [MW+1];

    assign row[0] = '0;

    for (genvar i = 0; i < MW; i++) begin : g_row
        logic [PW-1:0] pp;
        assign pp         = PW'(x & {MW{y[i]}}) << i;
        assign row[i + 1] = row[i] + pp;
    end

    assign p = row[MW];
endmodule

module mult12_seq_ctrl #(
    parameter int unsigned MW = 6,      // core operand width; only 6 is legal
    parameter int unsigned W  = 12      // operand width; must equal 2*MW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product,
    output logic           busy
);
    localparam int unsigned PW  = 2 * W;   // product / accumulator width
    localparam int unsigned CW  = 2 * MW;  // core product width
    localparam int unsigned SHW = 5;       // shift amount width (max shift 12)

`ifdef MULT12_ZERO_SKIP_EN
    localparam bit ZERO_SKIP = 1'b1;
`else
    localparam bit ZERO_SKIP = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [1:0]     cnt;
    logic [PW-1:0]  acc;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           skip;

    logic [MW-1:0]  core_x;
    logic [MW-1:0]  core_y;
    logic [CW-1:0]  core_p;
    logic [SHW-1:0] shamt;
    logic [PW-1:0]  pp_ext;
    logic [PW-1:0]  acc_next;

    // Pass select: cnt[0] picks the half of a, cnt[1] the half of b.
    // Driven only from registered state, so no input reaches the core.
    always_comb begin
        core_x = cnt[0] ? a_q[W-1:MW] : a_q[MW-1:0];
        core_y = cnt[1] ? b_q[W-1:MW] : b_q[MW-1:0];
        shamt  = '0;
        unique case (cnt)
            2'd0:    shamt = '0;
            2'd1:    shamt = SHW'(MW);
            2'd2:    shamt = SHW'(MW);
            default: shamt = SHW'(2 * MW);
        endcase
    end

    unsigned_array_mult #(.MW(MW)) u_core (
        .x (core_x),
        .y (core_y),
        .p (core_p)
    );

    // Zero-extend before shifting; 4095*4095 fits in 24 bits, so no overflow.
    assign pp_ext   = PW'(core_p) << shamt;
    assign acc_next = acc + pp_ext;

    // Sequencer with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            skip      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            product   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= b;
                        acc      <= '0;
                        cnt      <= '0;
                        skip     <= ZERO_SKIP && ((a == '0) || (b == '0));
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= MUL;
                    end
                end

                MUL: begin
                    if (skip) begin
                        // Zero operand: leave acc at 0 and issue no passes.
                        skip      <= 1'b0;
                        product   <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        acc <= acc_next;
                        if (cnt == 2'd3) begin
                            product   <= acc_next;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            cnt <= cnt + 2'd1;
                        end
                    end
                end

                DONE: begin
                    // product/out_valid hold until the consumer takes them.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult12_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult12_seq_ctrl
//   Scoreboard bench: each issued operand pair pushes the expected product and
//   latency (from plain integer arithmetic) into a queue. A negedge monitor
//   pops and compares on every output handshake, and checks latency and the
//   return to IDLE. Directed scenarios are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_mult12_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] a;
    logic [11:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] product;
    logic        busy;

    typedef struct {
        logic [23:0] p;
        int          lat;
    } exp_t;

    exp_t sb[$];

    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;
    bit   prev_ov = 1'b0;
    bit   exp_idle = 1'b0;
    bit   rnd_rdy = 1'b0;
    logic rdy_val = 1'b1;

    mult12_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    task automatic timeout(input string name);
        n_total++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Reference model: plain product; latency 4, or 1 for a skipped zero pair.
    function automatic exp_t model(input logic [11:0] x, input logic [11:0] y);
        exp_t e;
        e.p   = 24'(x) * 24'(y);
        e.lat = 4;
`ifdef MULT12_ZERO_SKIP_EN
        if (x == 12'h0 || y == 12'h0) e.lat = 1;
`endif
        return e;
    endfunction

    // Single driver of out_ready: fixed level or random backpressure.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_val;
        end
    end

    // Monitor / scoreboard checker.
    always @(negedge clk) begin
        if (rst) begin
            exp_idle = 1'b0;
            prev_ov  = 1'b0;
        end else begin
            if (exp_idle) begin
                chk("idle_after_handshake", {29'd0, in_ready, busy, out_valid}, 32'b100);
                exp_idle = 1'b0;
            end
            if (in_valid && in_ready) acc_cyc = cyc;
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
                else chk("latency", 32'(cyc - acc_cyc - 1), 32'(sb[0].lat));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_product", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("product", 32'(product), 32'(e.p));
                end
                exp_idle = 1'b1;
            end
            prev_ov = out_valid;
        end
    end

    // Issue one pair; entered and left at posedge+1.
    task automatic issue(input logic [11:0] x, input logic [11:0] y);
        int k = 0;
        while (!in_ready && k < 200) begin
            @(posedge clk); #1; k++;
        end
        if (!in_ready) begin
            timeout("issue_wait");
            return;
        end
        a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        sb.push_back(model(x, y));
        in_valid = 1'b0;
        a = 12'($urandom);
        b = 12'($urandom);
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((sb.size() != 0 || !in_ready) && k < 400) begin
            @(posedge clk); #1; k++;
        end
        if (k >= 400) timeout("drain");
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_product", 32'(product), 32'h0);

        // Max operands and cross terms
        issue(12'hFFF, 12'hFFF); wait_drain();
        issue(12'h03F, 12'h040); wait_drain();
        issue(12'hABC, 12'h123); wait_drain();

        // Backpressure with new operands presented
        rdy_val = 1'b0;
        issue(12'h00F, 12'h00F);
        begin
            int k = 0;
            while (!out_valid && k < 50) begin
                @(posedge clk); #1; k++;
            end
            if (!out_valid) timeout("bp_out_valid");
        end
        a = 12'h7A5; b = 12'h3C3; in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_product_held", 32'(product), 32'h0000E1);
            chk("bp_out_valid_held", 32'(out_valid), 32'd1);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        rdy_val  = 1'b1;
        wait_drain();

        // Reset during pass cnt=2
        issue(12'hFFF, 12'h001);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        sb.delete();
        rst = 1'b0;
        issue(12'h005, 12'h007); wait_drain();

        // Zero operands
        issue(12'h000, 12'h123); wait_drain();
        issue(12'h456, 12'h000); wait_drain();

        // Random traffic with random backpressure
        rnd_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [11:0] x;
            logic [11:0] y;
            x = ($urandom_range(0, 7) == 0) ? 12'h0 : 12'($urandom);
            y = ($urandom_range(0, 7) == 0) ? 12'h0 : 12'($urandom);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            issue(x, y);
        end
        wait_drain();
        rnd_rdy = 1'b0;
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
